// File: rtl/sec_countdown_if.sv
// Control/status bundle for the BCD mm:ss countdown timer.
// master: the controller that loads/starts the timer and watches its flags.
// slave:  the timer itself.
interface sec_countdown_if;
    logic       tick;
    logic       load;
    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic       start;
    logic       stop;
    logic       ack;
    logic [7:0] cur_min;
    logic [7:0] cur_sec;
    logic       running;
    logic       expired;
    logic       done_pulse;

    modport master (
        output tick, load, load_min, load_sec, start, stop, ack,
        input  cur_min, cur_sec, running, expired, done_pulse
    );

    modport slave (
        input  tick, load, load_min, load_sec, start, stop, ack,
        output cur_min, cur_sec, running, expired, done_pulse
    );
endinterface

// File: rtl/sec_countdown.sv
// sec_countdown: BCD mm:ss countdown timer with expiry flag and done pulse.
// Optional feature macro: SEC_COUNTDOWN_AUTO_RELOAD_EN -- when defined, the
// count reloads from the last loaded value on reaching zero and keeps running
// instead of entering DONE.

// One BCD digit of the borrow chain. When enabled it decrements, wrapping
// from 0 to WRAP (9 for ones digits, 5 for the seconds tens digit).
module sec_countdown_digit #(
    parameter logic [3:0] WRAP = 4'd9
) (
    input  logic [3:0] d,
    input  logic       en,
    output logic [3:0] q,
    output logic       zero
);
    assign zero = (d == 4'd0);
    assign q    = !en ? d : (zero ? WRAP : d - 4'd1);
endmodule

module sec_countdown #(
    parameter logic [7:0] MIN_MAX = 8'h59
) (
    input  logic            clk,
    input  logic            rst,
    sec_countdown_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [7:0] min;
        logic [7:0] sec;
    } mmss_t;

    // Digit order in the chain: [0]=sec ones, [1]=sec tens, [2]=min ones, [3]=min tens.
    localparam int NUM_DIG = 4;
    localparam logic [NUM_DIG-1:0][3:0] WRAP_TBL = {4'd9, 4'd9, 4'd5, 4'd9};

    state_t state_q, state_d;
    mmss_t  cnt_q, cnt_d;
    logic   running_q, expired_q, done_pulse_q, done_pulse_d;

`ifdef SEC_COUNTDOWN_AUTO_RELOAD_EN
    mmss_t  rld_q, rld_d;
`endif

    // Clamp one BCD digit to an upper limit.
    function automatic logic [3:0] clamp_dig(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // Load value after per-digit clamping; minutes saturate at MIN_MAX.
    mmss_t ld_val;
    logic [7:0] ld_min_dig;
    assign ld_min_dig = {bus.load_min[7:4], clamp_dig(bus.load_min[3:0], 4'd9)};
    assign ld_val.min = (ld_min_dig > MIN_MAX) ? MIN_MAX : ld_min_dig;
    assign ld_val.sec = {clamp_dig(bus.load_sec[7:4], 4'd5), clamp_dig(bus.load_sec[3:0], 4'd9)};

    // BCD borrow chain: a digit decrements only if every lower digit is zero.
    logic [NUM_DIG-1:0][3:0] cur_dig, dec_dig;
    logic [NUM_DIG-1:0]      dig_zero, dec_en;
    mmss_t                   dec_val;
    logic                    dec_is_zero, cnt_is_zero;

    assign cur_dig   = {cnt_q.min, cnt_q.sec};
    assign dec_en[0] = 1'b1;

    genvar g;
    generate
        for (g = 0; g < NUM_DIG; g++) begin : g_dig
            sec_countdown_digit #(.WRAP(WRAP_TBL[g])) u_dig (
                .d    (cur_dig[g]),
                .en   (dec_en[g]),
                .q    (dec_dig[g]),
                .zero (dig_zero[g])
            );
            if (g < NUM_DIG-1) begin : g_chain
                assign dec_en[g+1] = dec_en[g] & dig_zero[g];
            end
        end
    endgenerate

    assign dec_val     = {dec_dig[3], dec_dig[2], dec_dig[1], dec_dig[0]};
    assign dec_is_zero = (dec_val == '0);
    assign cnt_is_zero = (cnt_q == '0);

    // Next-state / next-count: load > ack > stop > start > tick.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        done_pulse_d = 1'b0;
`ifdef SEC_COUNTDOWN_AUTO_RELOAD_EN
        rld_d        = rld_q;
`endif
        if (bus.load) begin
            state_d = IDLE;
            cnt_d   = ld_val;
`ifdef SEC_COUNTDOWN_AUTO_RELOAD_EN
            rld_d   = ld_val;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    // A tick on the start edge is deliberately ignored.
                    if (bus.start && !cnt_is_zero)
                        state_d = RUN;
                end
                RUN: begin
                    if (bus.stop) begin
                        state_d = IDLE;
                    end else if (bus.tick) begin
                        done_pulse_d = dec_is_zero;
`ifdef SEC_COUNTDOWN_AUTO_RELOAD_EN
                        cnt_d = dec_is_zero ? rld_q : dec_val;
`else
                        cnt_d = dec_val;
                        if (dec_is_zero)
                            state_d = DONE;
`endif
                    end
                end
                DONE: begin
                    if (bus.ack)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, count and registered flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            running_q    <= 1'b0;
            expired_q    <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            running_q    <= (state_d == RUN);
            expired_q    <= (state_d == DONE);
            done_pulse_q <= done_pulse_d;
        end
    end

`ifdef SEC_COUNTDOWN_AUTO_RELOAD_EN
    // Reload register holds the last clamped load value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rld_q <= '0;
        else     rld_q <= rld_d;
    end
`endif

    assign bus.cur_min    = cnt_q.min;
    assign bus.cur_sec    = cnt_q.sec;
    assign bus.running    = running_q;
    assign bus.expired    = expired_q;
    assign bus.done_pulse = done_pulse_q;
endmodule

// File: tb/tb_sec_countdown.sv
// Directed bench for sec_countdown. Stimulus pushes the expected post-edge
// outputs onto a scoreboard queue; a monitor pops and compares after each edge.
module tb_sec_countdown;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sec_countdown_if bus();

    sec_countdown #(.MIN_MAX(8'h59)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       tag;
        logic [18:0] v;   // {min, sec, running, expired, done_pulse}
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [7:0] bcd(input int i);
        logic [7:0] r;
        r[7:4] = 4'(i / 10);
        r[3:0] = 4'(i % 10);
        return r;
    endfunction

    task automatic clear();
        bus.tick = 0; bus.load = 0; bus.load_min = 0; bus.load_sec = 0;
        bus.start = 0; bus.stop = 0; bus.ack = 0;
    endtask

    // Push what the outputs must be after the coming edge, then take that edge.
    task automatic chk(input string t, input logic [7:0] m, input logic [7:0] s,
                       input logic r, input logic x, input logic p);
        exp_t e;
        e.tag = t;
        e.v   = {m, s, r, x, p};
        sb.push_back(e);
        @(posedge clk);
        #2;
        clear();
    endtask

    task automatic ld(input logic [7:0] m, input logic [7:0] s);
        bus.load = 1; bus.load_min = m; bus.load_sec = s;
    endtask

    // Monitor: every edge, compare the DUT against the oldest expectation.
    always @(posedge clk) begin
        exp_t        e;
        logic [18:0] act;
        #1;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {bus.cur_min, bus.cur_sec, bus.running, bus.expired, bus.done_pulse};
            n_tests++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h:%h run=%b exp=%b dp=%b, want %h:%h run=%b exp=%b dp=%b",
                         e.tag, act[18:11], act[10:3], act[2], act[1], act[0],
                         e.v[18:11], e.v[10:3], e.v[2], e.v[1], e.v[0]);
            end
        end
    end

    initial begin
        clear();
        rst = 1;
        #2;
        chk("reset_state", 8'h00, 8'h00, 0, 0, 0);
        rst = 0;

        // Reset mid-RUN at 03:27 must act without waiting for an edge.
        ld(8'h03, 8'h27);            chk("load_0327", 8'h03, 8'h27, 0, 0, 0);
        bus.start = 1;               chk("start_0327", 8'h03, 8'h27, 1, 0, 0);
        rst = 1;
        #1;
        n_tests++;
        if ({bus.cur_min, bus.cur_sec, bus.running} !== 17'h0) begin
            n_fail++;
            $display("FAIL async_reset: got %h:%h run=%b, want 00:00 run=0",
                     bus.cur_min, bus.cur_sec, bus.running);
        end
        chk("reset_hold", 8'h00, 8'h00, 0, 0, 0);
        rst = 0;
        bus.start = 1;               chk("start_at_zero", 8'h00, 8'h00, 0, 0, 0);

        // Full minute countdown with back-to-back ticks.
        ld(8'h01, 8'h00);            chk("load_0100", 8'h01, 8'h00, 0, 0, 0);
        bus.start = 1;               chk("start_0100", 8'h01, 8'h00, 1, 0, 0);
        bus.tick = 1;                chk("tick_min_borrow", 8'h00, 8'h59, 1, 0, 0);
        for (int i = 58; i >= 1; i--) begin
            bus.tick = 1;            chk("tick_run", 8'h00, bcd(i), 1, 0, 0);
        end
`ifdef SEC_COUNTDOWN_AUTO_RELOAD_EN
        bus.tick = 1;                chk("tick_reload", 8'h01, 8'h00, 1, 0, 1);
        chk("reload_pulse_end", 8'h01, 8'h00, 1, 0, 0);
`else
        bus.tick = 1;                chk("tick_expire", 8'h00, 8'h00, 0, 1, 1);
        chk("pulse_one_cycle", 8'h00, 8'h00, 0, 1, 0);
        bus.start = 1; bus.tick = 1; chk("done_ignores", 8'h00, 8'h00, 0, 1, 0);
        bus.ack = 1;                 chk("ack", 8'h00, 8'h00, 0, 0, 0);
`endif

        // Clamping and borrow paths.
        ld(8'h7A, 8'h6F);            chk("load_clamp", 8'h59, 8'h59, 0, 0, 0);
        ld(8'h10, 8'h00);            chk("load_1000", 8'h10, 8'h00, 0, 0, 0);
        bus.start = 1;               chk("start_1000", 8'h10, 8'h00, 1, 0, 0);
        bus.tick = 1;                chk("tick_tens_borrow", 8'h09, 8'h59, 1, 0, 0);
        ld(8'h02, 8'h30);            chk("load_0230", 8'h02, 8'h30, 0, 0, 0);
        bus.start = 1;               chk("start_0230", 8'h02, 8'h30, 1, 0, 0);
        bus.tick = 1;                chk("tick_sec_borrow", 8'h02, 8'h29, 1, 0, 0);

        // Same-cycle priority at 00:05.
        ld(8'h00, 8'h05);            chk("load_0005", 8'h00, 8'h05, 0, 0, 0);
        bus.start = 1;               chk("start_0005", 8'h00, 8'h05, 1, 0, 0);
        bus.start = 1; bus.stop = 1; bus.tick = 1;
                                     chk("stop_wins", 8'h00, 8'h05, 0, 0, 0);
        bus.tick = 1;                chk("idle_tick", 8'h00, 8'h05, 0, 0, 0);
        bus.start = 1; bus.tick = 1; chk("start_no_dec", 8'h00, 8'h05, 1, 0, 0);
        bus.tick = 1;                chk("tick_after_start", 8'h00, 8'h04, 1, 0, 0);
        ld(8'h00, 8'h30); bus.tick = 1; bus.stop = 1;
                                     chk("load_wins", 8'h00, 8'h30, 0, 0, 0);

`ifdef SEC_COUNTDOWN_AUTO_RELOAD_EN
        ld(8'h00, 8'h02);            chk("ar_load", 8'h00, 8'h02, 0, 0, 0);
        bus.start = 1;               chk("ar_start", 8'h00, 8'h02, 1, 0, 0);
        bus.tick = 1;                chk("ar_tick1", 8'h00, 8'h01, 1, 0, 0);
        bus.tick = 1;                chk("ar_tick2", 8'h00, 8'h02, 1, 0, 1);
        chk("ar_hold", 8'h00, 8'h02, 1, 0, 0);
`else
        // Load out of DONE clears expired.
        ld(8'h00, 8'h01);            chk("load_0001", 8'h00, 8'h01, 0, 0, 0);
        bus.start = 1;               chk("start_0001", 8'h00, 8'h01, 1, 0, 0);
        bus.tick = 1;                chk("expire_0001", 8'h00, 8'h00, 0, 1, 1);
        ld(8'h00, 8'h02);            chk("load_from_done", 8'h00, 8'h02, 0, 0, 0);
`endif

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sec_countdown.md
# sec_countdown

BCD minutes:seconds countdown timer for the alarm clock. It is the decrementing counterpart of the seconds incrementer: it loads a BCD mm:ss value, counts it down once per 1 Hz tick with borrow from seconds into minutes, and flags expiry. It sits beside the timekeeping chain and drives the display mux and the alarm/buzzer control logic.

## Interface
Parameters:
- `MIN_MAX`, 8'h59: largest BCD minutes value accepted on load. Larger loads clamp to this value.

Ports:
- `clk`  in  1: system clock. One clock domain.
- `rst`  in  1: reset, asynchronous, active-high.
- `tick`  in  1: one-cycle 1 Hz enable pulse, synchronous to `clk`.
- `load`  in  1: load `load_min`/`load_sec`.
- `load_min`  in  8: BCD minutes, {tens, ones}.
- `load_sec`  in  8: BCD seconds, {tens, ones}.
- `start`  in  1: begin or resume counting.
- `stop`  in  1: pause counting.
- `ack`  in  1: acknowledge expiry.
- `cur_min`  out  8: current BCD minutes.
- `cur_sec`  out  8: current BCD seconds.
- `running`  out  1: high in RUN.
- `expired`  out  1: high in DONE.
- `done_pulse`  out  1: one-cycle pulse when the count reaches zero.

## Operation
- States: IDLE, RUN, DONE. Reset puts the block in IDLE with `cur_min`=`cur_sec`=8'h00 and `running`=`expired`=`done_pulse`=0. The reload register also resets to 00:00.
- Load clamping is applied per digit:
  - Any ones digit above 9 becomes 9.
  - Seconds tens digit above 5 becomes 5.
  - Minutes values above `MIN_MAX` become `MIN_MAX`.
  - The clamped value goes to both the count and the reload register.
- Priority within one cycle is `load` > `ack` > `stop` > `start` > `tick`.
- `load` is accepted in any state. It sets the count and goes to IDLE, clearing `expired`.
- `ack` is honoured only in DONE. It goes to IDLE and the count stays 00:00.
- In RUN, `stop` goes to IDLE and holds the count. `stop` together with `start` means stop.
- In IDLE, `start` goes to RUN only if the count is non-zero. `start` with a 00:00 count is ignored. `start` in DONE is ignored.
- Decrement on `tick` in RUN:
  - If sec ones > 0: decrement sec ones.
  - Else if sec tens > 0: sec ones becomes 9 and sec tens is decremented.
  - Else seconds become 8'h59 and minutes are decremented with the same BCD borrow (ones 0 → 9, tens − 1).
- A decrement that produces 00:00 moves RUN → DONE: `expired`=1 and `done_pulse`=1 for that one cycle.
- `tick` in IDLE or DONE is ignored.
- `rst` asserted mid-count returns immediately (asynchronously) to the reset state.

## Timing
- All outputs are registered.
- The count changes on the rising edge at which `tick` is sampled high. The new value is visible in the following cycle.
- `load` latency is one edge: the value, IDLE state and cleared `expired` are all visible in the next cycle.
- Counting starts on the first `tick` strictly after the edge that sampled `start`. A `tick` in the same cycle as `start` does not decrement.
- `done_pulse` and `expired` rise in the same cycle that `cur_min:cur_sec` first reads 00:00.
- `expired` holds high until `load`, `ack` or `rst`.
- Back-to-back `tick` on consecutive cycles is legal. Each one decrements.

## Configuration
- `SEC_COUNTDOWN_AUTO_RELOAD_EN` defined:
  - On reaching zero the count is reloaded from the reload register on the same edge, and the block stays in RUN.
  - `done_pulse` pulses for one cycle and `expired` stays 0. DONE is unreachable.
  - The output never shows 00:00 during RUN: it goes from 00:01 directly to the reload value.
- Not defined: single-shot behaviour as described above, and the reload register is not implemented.

## Test plan
- Reset mid-RUN at 03:27, then release → 00:00, IDLE, all flags 0. Then `start` → stays IDLE.
- Load 01:00, `start`, one `tick` → 00:59. Then 58 more ticks → 00:01. The next tick → 00:00 with `expired`=1 and `done_pulse` high for exactly 1 cycle. Then `ack` → IDLE with `expired`=0.
- Load min=8'h7A, sec=8'h6F with `MIN_MAX`=8'h59 → 59:59. Load 10:00, start, one tick → 09:59 (minutes tens borrow).
- In RUN at 00:05:
  - `start`+`stop`+`tick` in the same cycle → IDLE, count still 00:05.
  - `start`+`tick` in IDLE → RUN, count still 00:05. The next tick → 00:04.
  - `load` 00:30 with `tick` and `stop` in the same cycle → 00:30, IDLE.
- With `SEC_COUNTDOWN_AUTO_RELOAD_EN`: load 00:02, start, 2 ticks → 00:01 then 00:02, one `done_pulse`, `expired`=0, `running`=1 throughout.
